// File: rtl/mips_store_checker.sv
// rtl/mips_store_checker.sv - ordered expected-store monitor for a MIPS core
// Watches memwrite/aluout/writedata and reports pass/fail with reason code and offending store.
module mips_store_checker #(
    parameter int DEPTH   = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 1000,
    parameter int STRICT  = 1,
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cfg_we,
    input  logic [IDX_W-1:0]  cfg_idx,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_data,
    input  logic [CNT_W-1:0]  cfg_count,
    input  logic              start,
    input  logic              memwrite,
    input  logic [ADDR_W-1:0] aluout,
    input  logic [DATA_W-1:0] writedata,
    output logic              done,
    output logic              pass,
    output logic              fail,
    output logic [1:0]        fail_code,
    output logic [CNT_W-1:0]  match_count,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_data
);
    localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PASS, S_FAIL} state_t;

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CNT_W-1:0]  lim_q, lim_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [1:0]        code_q, code_d;
    logic [ADDR_W-1:0] faddr_q, faddr_d;
    logic [DATA_W-1:0] fdata_q, fdata_d;

    // Expected-store table is deliberately left out of reset so it survives re-arming.
    logic [ADDR_W-1:0] tab_addr_q [DEPTH];
    logic [DATA_W-1:0] tab_data_q [DEPTH];
    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic              hit;
    logic              cfg_bad;

    always_ff @(posedge clk) begin
        if (state_q == S_IDLE && cfg_we) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (cfg_idx == IDX_W'(i)) begin
                    tab_addr_q[i] <= cfg_addr;
                    tab_data_q[i] <= cfg_data;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            cnt_q   <= '0;
            lim_q   <= '0;
            timer_q <= '0;
            code_q  <= 2'd0;
            faddr_q <= '0;
            fdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            lim_q   <= lim_d;
            timer_q <= timer_d;
            code_q  <= code_d;
            faddr_q <= faddr_d;
            fdata_q <= fdata_d;
        end
    end

    always_comb begin
        exp_addr = '0;
        exp_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ptr_q == IDX_W'(i)) begin
                exp_addr = tab_addr_q[i];
                exp_data = tab_data_q[i];
            end
        end
        hit     = memwrite && (aluout == exp_addr) && (writedata == exp_data);
        cfg_bad = (cfg_count == '0) || (cfg_count > CNT_W'(DEPTH));

        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        lim_d   = lim_q;
        timer_d = timer_q;
        code_d  = code_q;
        faddr_d = faddr_q;
        fdata_d = fdata_q;

        case (state_q)
            S_RUN: begin
                if (hit) begin
                    ptr_d = ptr_q + 1'b1;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_d == lim_q) state_d = S_PASS;
                end else if (memwrite && STRICT != 0) begin
                    state_d = S_FAIL;
                    code_d  = 2'd1;
                    faddr_d = aluout;
                    fdata_d = writedata;
                end
                // Timeout only applies on edges that would otherwise stay in RUN.
                if (state_d == S_RUN) begin
                    if (timer_q == TW'(TIMEOUT - 1)) begin
                        state_d = S_FAIL;
                        code_d  = 2'd2;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
            end
            default: begin
                if (start) begin
                    lim_d   = cfg_count;
                    ptr_d   = '0;
                    cnt_d   = '0;
                    timer_d = '0;
                    faddr_d = '0;
                    fdata_d = '0;
                    if (cfg_bad) begin
                        state_d = S_FAIL;
                        code_d  = 2'd3;
                    end else begin
                        state_d = S_RUN;
                        code_d  = 2'd0;
                    end
                end
            end
        endcase
    end

    always_comb begin
        pass        = (state_q == S_PASS);
        fail        = (state_q == S_FAIL);
        done        = pass | fail;
        fail_code   = code_q;
        match_count = cnt_q;
        fail_addr   = faddr_q;
        fail_data   = fdata_q;
    end
endmodule

// File: tb/tb_mips_store_checker.sv
// tb/tb_mips_store_checker.sv - directed bench for mips_store_checker
// Three instances: strict/TIMEOUT=16, non-strict, and a single-entry table.
module tb_mips_store_checker;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_assert = 0;
    int n_fail   = 0;

    logic        reset, cfg_we, start, memwrite;
    logic [1:0]  cfg_idx;
    logic [2:0]  cfg_count;
    logic [31:0] cfg_addr, cfg_data, aluout, writedata;

    logic        a_done, a_pass, a_fail, b_done, b_pass, b_fail;
    logic [1:0]  a_code, b_code;
    logic [2:0]  a_cnt, b_cnt;
    logic [31:0] a_faddr, a_fdata, b_faddr, b_fdata;

    logic        c_cfg_we, c_cfg_idx, c_cfg_count, c_start, c_memwrite;
    logic [31:0] c_cfg_addr, c_cfg_data, c_aluout, c_writedata;
    logic        c_done, c_pass, c_fail, c_cnt;
    logic [1:0]  c_code;
    logic [31:0] c_faddr, c_fdata;

    mips_store_checker #(.DEPTH(4), .TIMEOUT(16), .STRICT(1)) dut_a (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_count(cfg_count),
        .start(start), .memwrite(memwrite), .aluout(aluout), .writedata(writedata),
        .done(a_done), .pass(a_pass), .fail(a_fail), .fail_code(a_code),
        .match_count(a_cnt), .fail_addr(a_faddr), .fail_data(a_fdata));

    mips_store_checker #(.DEPTH(4), .TIMEOUT(1000), .STRICT(0)) dut_b (
        .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx),
        .cfg_addr(cfg_addr), .cfg_data(cfg_data), .cfg_count(cfg_count),
        .start(start), .memwrite(memwrite), .aluout(aluout), .writedata(writedata),
        .done(b_done), .pass(b_pass), .fail(b_fail), .fail_code(b_code),
        .match_count(b_cnt), .fail_addr(b_faddr), .fail_data(b_fdata));

    mips_store_checker #(.DEPTH(1), .TIMEOUT(1000), .STRICT(1)) dut_c (
        .clk(clk), .reset(reset), .cfg_we(c_cfg_we), .cfg_idx(c_cfg_idx),
        .cfg_addr(c_cfg_addr), .cfg_data(c_cfg_data), .cfg_count(c_cfg_count),
        .start(c_start), .memwrite(c_memwrite), .aluout(c_aluout), .writedata(c_writedata),
        .done(c_done), .pass(c_pass), .fail(c_fail), .fail_code(c_code),
        .match_count(c_cnt), .fail_addr(c_faddr), .fail_data(c_fdata));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] d);
        memwrite = 1'b1; aluout = a; writedata = d;
        tick();
        memwrite = 1'b0;
    endtask

    task automatic arm(input logic [2:0] n);
        start = 1'b1; cfg_count = n;
        tick();
        start = 1'b0;
    endtask

    task automatic cfg(input logic [1:0] i, input logic [31:0] a, input logic [31:0] d);
        cfg_we = 1'b1; cfg_idx = i; cfg_addr = a; cfg_data = d;
        tick();
        cfg_we = 1'b0;
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; start = 1'b0; memwrite = 1'b0;
        cfg_idx = '0; cfg_count = '0; cfg_addr = '0; cfg_data = '0;
        aluout = '0; writedata = '0;
        c_cfg_we = 1'b0; c_cfg_idx = 1'b0; c_cfg_count = 1'b0; c_start = 1'b0;
        c_memwrite = 1'b0; c_cfg_addr = '0; c_cfg_data = '0; c_aluout = '0; c_writedata = '0;
        tick(); tick();
        reset = 1'b0;
        chk("reset_done", a_done, 0);
        chk("reset_code", a_code, 0);
        chk("reset_cnt", a_cnt, 0);
        chk("reset_faddr", a_faddr, 0);

        // 2+2 program on the single-entry instance; index 1 is out of range
        c_cfg_we = 1'b1; c_cfg_idx = 1'b0; c_cfg_addr = 68; c_cfg_data = 32'h1a; tick();
        c_cfg_idx = 1'b1; c_cfg_data = 32'h55; tick();
        c_cfg_we = 1'b0;
        c_start = 1'b1; c_cfg_count = 1'b1; tick(); c_start = 1'b0;
        repeat (5) tick();
        chk("c_done_before", c_done, 0);
        c_memwrite = 1'b1; c_aluout = 68; c_writedata = 32'h1a; tick(); c_memwrite = 1'b0;
        chk("c_pass", c_pass, 1);
        chk("c_code", c_code, 0);
        chk("c_cnt", c_cnt, 1);

        cfg(0, 4, 32'h11); cfg(1, 8, 32'h22); cfg(2, 12, 32'h33); cfg(3, 16, 32'h44);

        // ordered list: a is strict, b skips mismatches
        arm(3);
        chk("run_done", a_done, 0);
        store(4, 32'h11);
        chk("a_cnt1", a_cnt, 1);
        chk("b_cnt1", b_cnt, 1);
        store(8, 32'h99);
        chk("a_fail", a_fail, 1);
        chk("a_code1", a_code, 1);
        chk("a_faddr", a_faddr, 8);
        chk("a_fdata", a_fdata, 32'h99);
        chk("a_cnt_fail", a_cnt, 1);
        chk("b_skip", b_done, 0);
        store(100, 32'h5);
        store(8, 32'h22);
        chk("a_sticky_cnt", a_cnt, 1);
        chk("b_cnt2", b_cnt, 2);
        store(12, 32'h33);
        chk("b_pass", b_pass, 1);
        chk("b_cnt3", b_cnt, 3);
        chk("b_code", b_code, 0);
        chk("a_sticky_fail", a_code, 1);

        // timeout lands on the 16th RUN edge
        arm(3);
        repeat (15) tick();
        chk("to_not_yet", a_fail, 0);
        tick();
        chk("to_fail", a_fail, 1);
        chk("to_code", a_code, 2);

        // completing store on the 16th edge wins over timeout
        arm(1);
        repeat (15) tick();
        store(4, 32'h11);
        chk("to_pass", a_pass, 1);
        chk("to_pass_fail", a_fail, 0);
        chk("to_pass_code", a_code, 0);

        // config error, ignored cfg write outside IDLE, re-arm with retained table
        arm(0);
        chk("cfg0_fail", a_fail, 1);
        chk("cfg0_code", a_code, 3);
        cfg(0, 4, 32'h77);
        arm(1);
        chk("rearm_code", a_code, 0);
        chk("rearm_done", a_done, 0);
        store(4, 32'h11);
        chk("rearm_pass", a_pass, 1);
        arm(5);
        chk("cfg5_code", a_code, 3);

        // reset mid-run
        arm(3);
        store(4, 32'h11);
        chk("mid_cnt", a_cnt, 1);
        reset = 1'b1; tick(); reset = 1'b0;
        chk("rst_done", a_done, 0);
        chk("rst_cnt", a_cnt, 0);
        chk("rst_code", a_code, 0);
        store(4, 32'h11);
        chk("idle_store_cnt", a_cnt, 0);
        repeat (20) tick();
        chk("idle_no_timeout", a_done, 0);
        arm(1);
        store(4, 32'h11);
        chk("post_rst_pass", a_pass, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/mips_store_checker.md
# mips_store_checker

Synthesisable self-checking store monitor for the MIPS core testbenches and FPGA bring-up. It generalises the single "first store must be address 68 with data 0x1a" check into a programmable, ordered list of expected data-memory stores. It taps the core's `memwrite`, `aluout` and write-data buses and reports pass/fail with a reason code, progress count and the offending store. It sits beside `MipsTop`, is driven by the same clock, and is purely an observer.

## Interface
- `DEPTH`, 4: number of expected-store entries; minimum 1.
- `ADDR_W`, 32: store address width.
- `DATA_W`, 32: store data width.
- `TIMEOUT`, 1000: RUN cycles allowed before a timeout fail; minimum 1.
- `STRICT`, 1: 1 = any non-matching store fails; 0 = non-matching stores are skipped.
- `IDX_W` is derived internally as max(1, clog2(DEPTH)). `CNT_W` = clog2(DEPTH+1).

- `clk` in 1: core clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `cfg_we` in 1: write one table entry; honoured in IDLE only.
- `cfg_idx` in IDX_W: entry index for `cfg_we`.
- `cfg_addr` in ADDR_W: expected store address.
- `cfg_data` in DATA_W: expected store data.
- `cfg_count` in CNT_W: number of entries to check, 1..DEPTH; sampled with `start`.
- `start` in 1: arm or re-arm the check.
- `memwrite` in 1: core store strobe.
- `aluout` in ADDR_W: core store address.
- `writedata` in DATA_W: core store data (rd2).
- `done` out 1: pass | fail.
- `pass` out 1: all expected stores were seen.
- `fail` out 1: the check failed.
- `fail_code` out 2: 0 none, 1 mismatch, 2 timeout, 3 config error.
- `match_count` out CNT_W: number of entries matched so far.
- `fail_addr` out ADDR_W: address of the store that caused a mismatch.
- `fail_data` out DATA_W: data of the store that caused a mismatch.

## Operation
- States are IDLE, RUN, PASS and FAIL.
- Reset forces IDLE and clears every output, the pointer, the timer and the latched count. Table contents are not cleared.
- IDLE:
  - `cfg_we` writes entry `cfg_idx`.
  - Out-of-range `cfg_idx` is ignored.
  - `start` latches `cfg_count`. If it is 0 or greater than DEPTH, go to FAIL with code 3; otherwise go to RUN.
- Entering RUN clears the pointer, `match_count`, the timer, `fail_addr`, `fail_data` and `fail_code`.
- RUN, each rising edge with `memwrite`==1: compare (`aluout`, `writedata`) with entry[ptr], both fields exact.
  - Match: ptr++ and `match_count`++. If the new count equals the latched count, go to PASS.
  - Mismatch, STRICT=1: go to FAIL with code 1 and capture `aluout`/`writedata` into `fail_addr`/`fail_data`.
  - Mismatch, STRICT=0: no effect.
- RUN, timer:
  - Each RUN edge that does not leave RUN: if timer==TIMEOUT-1, go to FAIL with code 2; otherwise timer++.
  - A store that completes the list, or a strict mismatch, on the same edge takes priority over timeout.
- PASS and FAIL are sticky. All outputs hold until `reset`, or until `start`.
  - `start` in these states re-evaluates `cfg_count` exactly as in IDLE and re-arms.
  - The table is retained.
- `cfg_we` outside IDLE is ignored.
- `reset` and `start` asserted together: reset wins.

## Timing
- All outputs are registered.
- `start` is sampled at edge k and RUN begins after edge k. A store present at edge k is not checked.
- The completing store at edge n gives `pass`=`done`=1 from edge n onward, visible in cycle n+1.
- A strict mismatch at edge n gives `fail`=1, `fail_code`=1 and the captured store from edge n.
- Timeout: `fail` rises at the TIMEOUT-th RUN edge after entry, provided no completion has occurred.
- `match_count` updates on the same edge as the matching store.
- Config error: `fail`, with code 3, rises on the `start` edge.
- `reset` mid-RUN: IDLE after that edge, and all outputs are 0 in the next cycle.

## Test plan
- 2+2 program:
  - Setup: DEPTH=1, table {68, 0x1a}, count 1, `start`.
  - Stimulus: one store addr 68 / data 0x1a, 5 cycles later.
  - Required: `pass`=1, `fail_code`=0, `match_count`=1.
- Ordered list, STRICT=1:
  - Setup: table {4,0x11},{8,0x22},{12,0x33}.
  - Stimulus: stores 4/0x11, then 8/0x99.
  - Required: `fail`=1, code 1, `fail_addr`=8, `fail_data`=0x99, `match_count`=1.
- STRICT=0:
  - Setup: same table as the ordered-list scenario.
  - Stimulus: stores 4/0x11, 100/0x5, 8/0x22, 12/0x33.
  - Required: `pass`=1, `match_count`=3.
- Timeout:
  - Setup: TIMEOUT=16, `start`.
  - Stimulus: no stores.
  - Required: `fail`=1, code 2, exactly 16 cycles after RUN entry. Also, a completing store on the 16th edge gives `pass` instead.
- Config and re-arm:
  - Stimulus: `cfg_count`=0 with `start`.
  - Required: code 3 on that edge.
  - Then: `start` with count 1 and a matching store gives `pass`, with the table retained.
- Reset mid-run:
  - Stimulus: after 1 of 3 matches, assert `reset` for 1 cycle.
  - Required: all outputs 0 and IDLE. A store after reset has no effect until `start`.
